// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue bus: dual-port instruction memory lookup, redirect and decode handshake.
interface inst_fetch_queue_if;
  logic [4:0]  dir;
  logic [4:0]  dir2;
  logic [31:0] ins;
  logic [31:0] ins2;
  logic        redirect;
  logic [4:0]  redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_ins;
  logic [4:0]  out_pc;

  modport slave (
    input  ins, ins2, redirect, redirect_pc, out_ready,
    output dir, dir2, out_valid, out_ins, out_pc
  );

  modport master (
    output ins, ins2, redirect, redirect_pc, out_ready,
    input  dir, dir2, out_valid, out_ins, out_pc
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Four-entry instruction fetch queue: fetches up to two words per cycle from a
// dual-ported instruction memory and hands them to decode in fetch order.
module inst_fetch_queue #(
  parameter logic [4:0] RESET_PC = 5'h00
) (
  input  logic                  clk,
  input  logic                  rst_n,
  inst_fetch_queue_if.slave     bus
);

  localparam int DEPTH = 4;

  logic [4:0]  fetch_pc_r;
  logic [4:0]  q_pc_r  [DEPTH];
  logic [31:0] q_ins_r [DEPTH];
  logic [1:0]  rd_ptr_r;
  logic [1:0]  wr_ptr_r;
  logic [2:0]  count_r;

  logic [2:0]  free_s;
  logic [1:0]  push_s;
  logic        valid_s;
  logic        pop_s;
  logic [1:0]  wr_ptr_b_s;

  function automatic logic [4:0] pc_add(input logic [4:0] pc, input logic [1:0] n);
    return pc + {3'b000, n};
  endfunction

  // Push sizing uses registered occupancy only, so a same-cycle pop never frees a slot.
  always_comb begin
    free_s     = 3'd4 - count_r;
    valid_s    = (count_r != 3'd0) && !bus.redirect;
    pop_s      = valid_s && bus.out_ready;
    wr_ptr_b_s = wr_ptr_r + 2'd1;
    if (bus.redirect) begin
      push_s = 2'd0;
    end else if (free_s >= 3'd2) begin
      push_s = 2'd2;
    end else if (free_s == 3'd1) begin
      push_s = 2'd1;
    end else begin
      push_s = 2'd0;
    end
  end

  // Memory addresses follow fetch_pc; decode sees only stored entries.
  always_comb begin
    bus.dir       = fetch_pc_r;
    bus.dir2      = pc_add(fetch_pc_r, 2'd1);
    bus.out_valid = valid_s;
    bus.out_pc    = q_pc_r[rd_ptr_r];
    bus.out_ins   = q_ins_r[rd_ptr_r];
  end

  // Queue storage, pointers, occupancy and fetch address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_r <= RESET_PC;
      rd_ptr_r   <= 2'd0;
      wr_ptr_r   <= 2'd0;
      count_r    <= 3'd0;
      for (int i = 0; i < DEPTH; i++) begin
        q_pc_r[i]  <= 5'h00;
        q_ins_r[i] <= 32'h0000_0000;
      end
    end else if (bus.redirect) begin
      fetch_pc_r <= bus.redirect_pc;
      rd_ptr_r   <= 2'd0;
      wr_ptr_r   <= 2'd0;
      count_r    <= 3'd0;
    end else begin
      if (push_s != 2'd0) begin
        q_pc_r[wr_ptr_r]  <= fetch_pc_r;
        q_ins_r[wr_ptr_r] <= bus.ins;
      end
      // Port B entry lands behind port A so fetch order is preserved.
      if (push_s == 2'd2) begin
        q_pc_r[wr_ptr_b_s]  <= pc_add(fetch_pc_r, 2'd1);
        q_ins_r[wr_ptr_b_s] <= bus.ins2;
      end
      wr_ptr_r   <= wr_ptr_r + push_s;
      rd_ptr_r   <= rd_ptr_r + {1'b0, pop_s};
      count_r    <= count_r + {1'b0, push_s} - {2'b00, pop_s};
      fetch_pc_r <= pc_add(fetch_pc_r, push_s);
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: cycle table plus scoreboarded sequences.
module tb_inst_fetch_queue;

  logic clk;
  logic rst_n;
  inst_fetch_queue_if bus ();

  inst_fetch_queue #(.RESET_PC(5'h00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  logic [31:0] imem [32];
  assign bus.ins  = imem[bus.dir];
  assign bus.ins2 = imem[bus.dir2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        redir;
    logic [4:0]  rpc;
    logic        vld;
    logic        chkd;
    logic [4:0]  pc;
    logic [31:0] ins;
    logic [4:0]  d;
    logic [4:0]  d2;
  } vec_t;

  typedef struct {
    logic [4:0]  pc;
    logic [31:0] ins;
  } ent_t;

  vec_t tbl [10];
  ent_t exp_q [$];
  ent_t mon_e;
  int   n_checks;
  int   n_errors;
  int   delivered;
  logic sb_en;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load_sb(input logic [4:0] start, input int n);
    logic [4:0] p;
    exp_q.delete();
    delivered = 0;
    for (int i = 0; i < n; i++) begin
      p = start + 5'(i);
      exp_q.push_back('{p, imem[p]});
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset held over two edges; leaves the bench at cycle 0 just after release.
  task automatic do_reset();
    rst_n = 1'b0;
    bus.out_ready = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 5'h00;
    step();
    step();
    chk("rst_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_dir", 32'(bus.dir), 32'h00);
    chk("rst_dir2", 32'(bus.dir2), 32'h01);
    chk("rst_pc", 32'(bus.out_pc), 32'h00);
    chk("rst_ins", bus.out_ins, 32'h0);
    rst_n = 1'b1;
  endtask

  // Scoreboard: each accepted head entry must match the next expected fetch.
  always @(negedge clk) begin
    if (sb_en && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_extra: got pc %h expected none", bus.out_pc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_pc", 32'(bus.out_pc), 32'(mon_e.pc));
        chk("sb_ins", bus.out_ins, mon_e.ins);
        delivered++;
      end
    end
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    delivered = 0;
    sb_en = 1'b0;
    rst_n = 1'b0;
    bus.out_ready = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 5'h00;
    for (int i = 0; i < 32; i++) imem[i] = 32'hA500_0000 | 32'(i);
    imem[0]  = 32'h0022_1803;
    imem[1]  = 32'h0C85_0001;
    imem[2]  = 32'h0106_3804;
    imem[3]  = 32'h016C_2005;
    imem[20] = 32'h1021_0000;
    imem[31] = 32'h0000_0000;

    // rdy redir rpc vld chkd pc ins d d2
    tbl[0] = '{1'b1, 1'b0, 5'h00, 1'b0, 1'b0, 5'h00, 32'h0000_0000, 5'h00, 5'h01};
    tbl[1] = '{1'b1, 1'b0, 5'h00, 1'b1, 1'b1, 5'h00, 32'h0022_1803, 5'h02, 5'h03};
    tbl[2] = '{1'b1, 1'b0, 5'h00, 1'b1, 1'b1, 5'h01, 32'h0C85_0001, 5'h04, 5'h05};
    tbl[3] = '{1'b1, 1'b0, 5'h00, 1'b1, 1'b1, 5'h02, 32'h0106_3804, 5'h05, 5'h06};
    tbl[4] = '{1'b1, 1'b0, 5'h00, 1'b1, 1'b1, 5'h03, 32'h016C_2005, 5'h06, 5'h07};
    tbl[5] = '{1'b1, 1'b0, 5'h00, 1'b1, 1'b1, 5'h04, 32'hA500_0004, 5'h07, 5'h08};
    tbl[6] = '{1'b1, 1'b1, 5'h1F, 1'b0, 1'b0, 5'h00, 32'h0000_0000, 5'h08, 5'h09};
    tbl[7] = '{1'b1, 1'b0, 5'h00, 1'b0, 1'b0, 5'h00, 32'h0000_0000, 5'h1F, 5'h00};
    tbl[8] = '{1'b1, 1'b0, 5'h00, 1'b1, 1'b1, 5'h1F, 32'h0000_0000, 5'h01, 5'h02};
    tbl[9] = '{1'b1, 1'b0, 5'h00, 1'b1, 1'b1, 5'h00, 32'h0022_1803, 5'h03, 5'h04};

    // Streaming after reset, then a redirect to the last word (address wrap).
    do_reset();
    for (int r = 0; r < 10; r++) begin
      bus.out_ready = tbl[r].rdy;
      bus.redirect = tbl[r].redir;
      bus.redirect_pc = tbl[r].rpc;
      @(negedge clk);
      chk("tbl_valid", 32'(bus.out_valid), 32'(tbl[r].vld));
      chk("tbl_dir", 32'(bus.dir), 32'(tbl[r].d));
      chk("tbl_dir2", 32'(bus.dir2), 32'(tbl[r].d2));
      if (tbl[r].chkd) begin
        chk("tbl_pc", 32'(bus.out_pc), 32'(tbl[r].pc));
        chk("tbl_ins", bus.out_ins, tbl[r].ins);
      end
      step();
    end
    bus.redirect = 1'b0;

    // Back-pressure: queue fills in two edges, head must hold, then drain gap-free.
    do_reset();
    @(negedge clk);
    chk("bp_dir_c0", 32'(bus.dir), 32'h00);
    step();
    @(negedge clk);
    chk("bp_dir_c1", 32'(bus.dir), 32'h02);
    for (int c = 0; c < 4; c++) begin
      step();
      @(negedge clk);
      chk("bp_dir_full", 32'(bus.dir), 32'h04);
      chk("bp_valid", 32'(bus.out_valid), 32'h1);
      chk("bp_hold_pc", 32'(bus.out_pc), 32'h00);
      chk("bp_hold_ins", bus.out_ins, 32'h0022_1803);
    end
    step();
    load_sb(5'h00, 10);
    sb_en = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      step();
    end
    sb_en = 1'b0;
    bus.out_ready = 1'b0;
    chk("bp_delivered", 32'(delivered), 32'd10);
    chk("bp_sb_left", 32'(exp_q.size()), 32'd0);

    // Random out_ready toggling, then redirect with three entries queued.
    do_reset();
    load_sb(5'h00, 40);
    sb_en = 1'b1;
    for (int c = 0; c < 30; c++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      step();
    end
    bus.out_ready = 1'b1;
    step();
    step();
    chk("tog_progress", 32'(delivered > 0), 32'h1);
    bus.redirect = 1'b1;
    bus.redirect_pc = 5'h14;
    load_sb(5'h14, 9);
    @(negedge clk);
    chk("rd_valid_low", 32'(bus.out_valid), 32'h0);
    step();
    bus.redirect = 1'b0;
    @(negedge clk);
    chk("rd_valid_c1", 32'(bus.out_valid), 32'h0);
    chk("rd_dir", 32'(bus.dir), 32'h14);
    chk("rd_dir2", 32'(bus.dir2), 32'h15);
    step();
    @(negedge clk);
    chk("rd_first_valid", 32'(bus.out_valid), 32'h1);
    chk("rd_first_pc", 32'(bus.out_pc), 32'h14);
    chk("rd_first_ins", bus.out_ins, 32'h1021_0000);
    for (int c = 0; c < 9; c++) begin
      step();
      if (c < 8) @(negedge clk);
    end
    sb_en = 1'b0;
    bus.out_ready = 1'b0;
    chk("rd_delivered", 32'(delivered), 32'd9);

    // Asynchronous reset between edges with a full queue.
    do_reset();
    step();
    step();
    step();
    @(negedge clk);
    chk("ar_pre_valid", 32'(bus.out_valid), 32'h1);
    chk("ar_pre_dir", 32'(bus.dir), 32'h04);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(bus.out_valid), 32'h0);
    chk("ar_dir", 32'(bus.dir), 32'h00);
    chk("ar_dir2", 32'(bus.dir2), 32'h01);
    chk("ar_pc", 32'(bus.out_pc), 32'h00);
    chk("ar_ins", bus.out_ins, 32'h0);
    #1;
    rst_n = 1'b1;
    load_sb(5'h00, 6);
    sb_en = 1'b1;
    bus.out_ready = 1'b1;
    step();
    repeat (6) @(negedge clk);
    step();
    sb_en = 1'b0;
    bus.out_ready = 1'b0;
    chk("ar_delivered", 32'(delivered), 32'd6);
    chk("ar_sb_left", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
